// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
//
// Byte-command sequencer for the MIPS pipeline. It sits between the host
// byte stream (typically the UART receiver) and the instruction-fetch stage.
// It does three jobs:
//   - loads a program into instruction memory, one word at a time;
//   - resets the pipeline and then lets it run freely or single-steps it;
//   - holds the pipeline frozen at all other times.
//
// Commands accepted in IDLE:
//   'L' N b0 b1 b2 b3 ...  load N words, each sent MSB first, starting at
//                          address 0.
//   'C'                    pulse the pipeline reset, then run until
//                          i_end_detect.
//   'S'                    pulse the pipeline reset, then single-step.
//                          In STEP, 'N' releases the pipeline for one cycle
//                          and 'E' leaves without a done pulse.
//
// Optional feature: the macro PIPE_CTRL_STEP_EN enables the STEP state.
// When the macro is undefined, 'S' is an unknown command and sets o_err.
//
// Ports:
//   clk           single clock, rising edge
//   i_rst         synchronous active-high reset
//   i_rx_data     incoming byte, qualified by i_rx_valid
//   i_rx_valid    one-cycle strobe
//   i_end_detect  pipeline retired its HALT instruction
//   o_instr_we    instruction-memory write strobe
//   o_instr_addr  instruction-memory word address
//   o_instr_data  instruction word to write
//   o_pipe_rst    one-cycle pipeline reset pulse
//   o_halt        freezes the PC and the pipeline registers
//   o_done        one-cycle pulse when the program ends
//   o_err         sticky protocol error; cleared by the next accepted command
//   o_state       current state encoding, for debug
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int NB_DATA   = 32,
    parameter int NB_BYTE   = 8,
    parameter int MAX_INSTR = 256,
    parameter int NB_ADDR   = 8
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_end_detect,
    output logic               o_instr_we,
    output logic [NB_ADDR-1:0] o_instr_addr,
    output logic [NB_DATA-1:0] o_instr_data,
    output logic               o_pipe_rst,
    output logic               o_halt,
    output logic               o_done,
    output logic               o_err,
    output logic [2:0]         o_state
);

    localparam int BYTES      = NB_DATA / NB_BYTE;
    localparam int NB_IDX     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int NB_CNT_MIN = $clog2(MAX_INSTR + 1);
    // The word count must hold both any received N byte and MAX_INSTR itself.
    localparam int NB_CNT     = (NB_BYTE > NB_CNT_MIN) ? NB_BYTE : NB_CNT_MIN;

    localparam logic [NB_IDX-1:0]  LAST_IDX = NB_IDX'(BYTES - 1);
    localparam logic [NB_CNT-1:0]  MAX_CNT  = NB_CNT'(MAX_INSTR);
    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'(8'h43);
`ifdef PIPE_CTRL_STEP_EN
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_NEXT = NB_BYTE'(8'h4E);
    localparam logic [NB_BYTE-1:0] CMD_END  = NB_BYTE'(8'h45);
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_CNT  = 3'd1,
        LOAD_DATA = 3'd2,
        RST_PIPE  = 3'd3,
        RUN       = 3'd4
`ifdef PIPE_CTRL_STEP_EN
        ,STEP     = 3'd5
`endif
    } state_t;

    state_t               state_reg, state_next;
    logic                 halt_reg, halt_next;
    logic                 we_reg, we_next;
    logic [NB_ADDR-1:0]   addr_reg, addr_next;
    logic [NB_DATA-1:0]   data_reg, data_next;
    logic                 pipe_rst_reg, pipe_rst_next;
    logic                 done_reg, done_next;
    logic                 err_reg, err_next;
    logic [NB_CNT-1:0]    n_reg, n_next;
    logic [NB_CNT-1:0]    word_cnt_reg, word_cnt_next;
    logic [NB_IDX-1:0]    byte_idx_reg, byte_idx_next;
    logic [NB_ADDR-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [NB_DATA-1:0]   asm_reg, asm_next;
`ifdef PIPE_CTRL_STEP_EN
    logic                 mode_step_reg, mode_step_next;
`endif

    logic                 step_pulse;
    logic [NB_CNT-1:0]    n_in;
    logic [NB_CNT-1:0]    word_cnt_inc;
    logic [NB_DATA-1:0]   asm_shift;

    assign n_in         = NB_CNT'(i_rx_data);
    assign word_cnt_inc = word_cnt_reg + NB_CNT'(1);
    assign asm_shift    = {asm_reg[NB_DATA-NB_BYTE-1:0], i_rx_data};

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            halt_reg      <= 1'b1;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            pipe_rst_reg  <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            n_reg         <= '0;
            word_cnt_reg  <= '0;
            byte_idx_reg  <= '0;
            wr_ptr_reg    <= '0;
            asm_reg       <= '0;
`ifdef PIPE_CTRL_STEP_EN
            mode_step_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            halt_reg      <= halt_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            pipe_rst_reg  <= pipe_rst_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            n_reg         <= n_next;
            word_cnt_reg  <= word_cnt_next;
            byte_idx_reg  <= byte_idx_next;
            wr_ptr_reg    <= wr_ptr_next;
            asm_reg       <= asm_next;
`ifdef PIPE_CTRL_STEP_EN
            mode_step_reg <= mode_step_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        we_next        = 1'b0;
        addr_next      = addr_reg;
        data_next      = data_reg;
        pipe_rst_next  = 1'b0;
        done_next      = 1'b0;
        err_next       = err_reg;
        n_next         = n_reg;
        word_cnt_next  = word_cnt_reg;
        byte_idx_next  = byte_idx_reg;
        wr_ptr_next    = wr_ptr_reg;
        asm_next       = asm_reg;
        step_pulse     = 1'b0;
`ifdef PIPE_CTRL_STEP_EN
        mode_step_next = mode_step_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_next = LOAD_CNT;
                            err_next   = 1'b0;
                        end
                        CMD_CONT: begin
                            state_next    = RST_PIPE;
                            pipe_rst_next = 1'b1;
                            err_next      = 1'b0;
`ifdef PIPE_CTRL_STEP_EN
                            mode_step_next = 1'b0;
`endif
                        end
`ifdef PIPE_CTRL_STEP_EN
                        CMD_STEP: begin
                            state_next     = RST_PIPE;
                            pipe_rst_next  = 1'b1;
                            err_next       = 1'b0;
                            mode_step_next = 1'b1;
                        end
`endif
                        default: err_next = 1'b1;
                    endcase
                end
            end
            LOAD_CNT: begin
                if (i_rx_valid) begin
                    if (n_in == '0 || n_in > MAX_CNT) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        n_next        = n_in;
                        word_cnt_next = '0;
                        byte_idx_next = '0;
                        wr_ptr_next   = '0;
                        addr_next     = '0;
                        state_next    = LOAD_DATA;
                    end
                end
            end
            LOAD_DATA: begin
                if (i_rx_valid) begin
                    asm_next = asm_shift;
                    if (byte_idx_reg == LAST_IDX) begin
                        // The output address register shows the address being
                        // written. The internal pointer runs one ahead, so the
                        // output keeps the last written address after the load.
                        we_next       = 1'b1;
                        addr_next     = wr_ptr_reg;
                        data_next     = asm_shift;
                        wr_ptr_next   = wr_ptr_reg + NB_ADDR'(1);
                        byte_idx_next = '0;
                        word_cnt_next = word_cnt_inc;
                        if (word_cnt_inc == n_reg) begin
                            state_next = IDLE;
                        end
                    end else begin
                        byte_idx_next = byte_idx_reg + NB_IDX'(1);
                    end
                end
            end
            RST_PIPE: begin
`ifdef PIPE_CTRL_STEP_EN
                state_next = mode_step_reg ? STEP : RUN;
`else
                state_next = RUN;
`endif
            end
            RUN: begin
                if (i_end_detect) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
`ifdef PIPE_CTRL_STEP_EN
            STEP: begin
                // End of program takes priority over a step request that
                // arrives in the same cycle.
                if (i_end_detect) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (i_rx_valid) begin
                    if (i_rx_data == CMD_NEXT) begin
                        step_pulse = 1'b1;
                    end else if (i_rx_data == CMD_END) begin
                        state_next = IDLE;
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        // The pipeline advances only while running or during a single step.
        halt_next = !((state_next == RUN) || step_pulse);
    end

    assign o_instr_we   = we_reg;
    assign o_instr_addr = addr_reg;
    assign o_instr_data = data_reg;
    assign o_pipe_rst   = pipe_rst_reg;
    assign o_halt       = halt_reg;
    assign o_done       = done_reg;
    assign o_err        = err_reg;
    assign o_state      = state_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// The stimulus process sends directed byte sequences. For each sequence it
// pushes the expected output events into a queue. Each event records its kind
// (write, pipeline reset, done, released cycle), its payload and the clock
// edge at which it must appear.
//
// The monitor process samples the outputs on every falling edge. Each
// observed event pops the queue and is compared. Level outputs (state, err,
// halt, reset values) are checked directly by the stimulus process.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int EV_WE   = 0;
    localparam int EV_PRST = 1;
    localparam int EV_DONE = 2;
    localparam int EV_RUN  = 3;

    typedef struct {
        int          kind;
        logic [7:0]  a;
        logic [31:0] d;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        end_det;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        prst;
    logic        halt;
    logic        done;
    logic        err;
    logic [2:0]  state;

    int  edge_cnt = 0;
    int  n_cmp    = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;
    ev_t exp_q[$];

    pipeline_ctrl #(
        .NB_DATA  (32),
        .NB_BYTE  (8),
        .MAX_INSTR(256),
        .NB_ADDR  (8)
    ) dut (
        .clk         (clk),
        .i_rst       (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_end_detect(end_det),
        .o_instr_we  (we),
        .o_instr_addr(addr),
        .o_instr_data(data),
        .o_pipe_rst  (prst),
        .o_halt      (halt),
        .o_done      (done),
        .o_err       (err),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic string kname(input int k);
        case (k)
            EV_WE:   return "write";
            EV_PRST: return "pipe_rst";
            EV_DONE: return "done";
            default: return "released";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input logic [7:0] a, input logic [31:0] d, input int cyc);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] a, input logic [31:0] d);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got addr=%h data=%h at edge %0d, required no event",
                     kname(kind), a, d, edge_cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.d != d || e.cyc != edge_cnt) begin
                n_fail++;
                $display("FAIL event_%s: got %s addr=%h data=%h edge %0d, required %s addr=%h data=%h edge %0d",
                         kname(e.kind), kname(kind), a, d, edge_cnt,
                         kname(e.kind), e.a, e.d, e.cyc);
            end else begin
                $display("ok %s addr=%h data=%h edge %0d", kname(kind), a, d, edge_cnt);
            end
        end
    endtask

    // The spec allows at most one of these events per cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (we)    observe(EV_WE, addr, data);
            if (prst)  observe(EV_PRST, 8'h00, 32'h0);
            if (done)  observe(EV_DONE, 8'h00, 32'h0);
            if (!halt) observe(EV_RUN, 8'h00, 32'h0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_halt"},  32'(halt),  32'd1);
        chk({tag, "_we"},    32'(we),    32'd0);
        chk({tag, "_addr"},  32'(addr),  32'd0);
        chk({tag, "_data"},  data,       32'd0);
        chk({tag, "_prst"},  32'(prst),  32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_err"},   32'(err),   32'd0);
    endtask

    // Called on a falling edge. The byte is sampled at the next rising edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    logic [7:0] load1 [10] = '{8'h4C, 8'h02, 8'h00, 8'h22, 8'h18, 8'h21,
                               8'h20, 8'hA2, 8'h00, 8'h04};
    logic [7:0] load2 [6]  = '{8'h4C, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    initial begin
        int e;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        end_det  = 1'b0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        chk_reset("reset");

        // Two-word load, back-to-back bytes.
        e = edge_cnt;
        expect_ev(EV_WE, 8'd0, 32'h00221821, e + 6);
        expect_ev(EV_WE, 8'd1, 32'h20A20004, e + 10);
        for (int i = 0; i < 10; i++) send(load1[i]);
        chk("load_state", 32'(state), 32'd0);
        chk("load_halt",  32'(halt),  32'd1);
        @(negedge clk);
        chk("load_addr_hold", 32'(addr), 32'd1);
        chk("load_data_hold", data, 32'h20A20004);

        // Zero-length load is rejected.
        send(8'h4C);
        send(8'h00);
        chk("n0_err",   32'(err),   32'd1);
        chk("n0_state", 32'(state), 32'd0);

        // Run: 'C' clears the error, then 10 free cycles, then end_detect.
        e = edge_cnt + 1;
        expect_ev(EV_PRST, 8'h00, 32'h0, e);
        for (int i = 1; i <= 10; i++) expect_ev(EV_RUN, 8'h00, 32'h0, e + i);
        expect_ev(EV_DONE, 8'h00, 32'h0, e + 11);
        send(8'h43);
        chk("c_err_clr",  32'(err),   32'd0);
        chk("c_state_rp", 32'(state), 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk("run_state", 32'(state), 32'd4);
        end
        end_det = 1'b1;
        @(negedge clk);
        end_det = 1'b0;
        chk("run_end_state", 32'(state), 32'd0);
        chk("run_end_halt",  32'(halt),  32'd1);

        // end_detect is ignored in IDLE.
        end_det = 1'b1;
        @(negedge clk);
        end_det = 1'b0;
        @(negedge clk);
        chk("idle_end_state", 32'(state), 32'd0);

        // Unknown command sets the error.
        send(8'h7A);
        chk("unk_err",   32'(err),   32'd1);
        chk("unk_state", 32'(state), 32'd0);

`ifdef PIPE_CTRL_STEP_EN
        // Two steps, one ignored byte, then 'E' (no done).
        e = edge_cnt + 1;
        expect_ev(EV_PRST, 8'h00, 32'h0, e);
        expect_ev(EV_RUN,  8'h00, 32'h0, e + 2);
        expect_ev(EV_RUN,  8'h00, 32'h0, e + 4);
        send(8'h53);
        chk("s_err_clr", 32'(err), 32'd0);
        @(negedge clk);
        chk("step_state", 32'(state), 32'd5);
        send(8'h4E);
        send(8'h41);
        send(8'h4E);
        send(8'h45);
        chk("step_exit_state", 32'(state), 32'd0);
        chk("step_exit_halt",  32'(halt),  32'd1);

        // 'N' together with end_detect: end wins.
        e = edge_cnt + 1;
        expect_ev(EV_PRST, 8'h00, 32'h0, e);
        expect_ev(EV_DONE, 8'h00, 32'h0, e + 2);
        send(8'h53);
        @(negedge clk);
        end_det = 1'b1;
        send(8'h4E);
        end_det = 1'b0;
        chk("step_end_state", 32'(state), 32'd0);
        chk("step_end_halt",  32'(halt),  32'd1);
`else
        send(8'h53);
        chk("s_disabled_err",   32'(err),   32'd1);
        chk("s_disabled_state", 32'(state), 32'd0);
`endif

        // Reset in the middle of a load discards the partial word.
        send(8'h4C);
        chk("l_err_clr",    32'(err),   32'd0);
        chk("l_state_cnt",  32'(state), 32'd1);
        send(8'h01);
        send(8'h00);
        send(8'h22);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("midload_rst");

        // A fresh load afterwards starts at address 0.
        e = edge_cnt;
        expect_ev(EV_WE, 8'd0, 32'hDEADBEEF, e + 6);
        for (int i = 0; i < 6; i++) send(load2[i]);
        chk("reload_state", 32'(state), 32'd0);

        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d left in queue, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Command-driven controller that sequences the MIPS pipeline from a byte stream, typically the UART RX output. It loads a program into instruction memory word by word, then either runs the pipeline freely or single-steps it, and holds it frozen otherwise. It sits between the host interface and the instruction-fetch stage, driving the instruction-memory write port, the pipeline reset and the halt/stall control.

## Interface

Parameters:
- NB_DATA, 32, instruction word width.
- NB_BYTE, 8, command/data byte width.
- MAX_INSTR, 256, maximum words per load; must be ≤ 2^NB_ADDR.
- NB_ADDR, 8, instruction word-address width.

Ports:
- clk  in  1  single clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_rx_data  in  NB_BYTE  incoming byte.
- i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data.
- i_end_detect  in  1  pipeline retired its HALT instruction.
- o_instr_we  out  1  instruction-memory write strobe.
- o_instr_addr  out  NB_ADDR  instruction-memory word address.
- o_instr_data  out  NB_DATA  instruction word to write.
- o_pipe_rst  out  1  active-high pipeline reset pulse; clears the PC and the pipeline registers.
- o_halt  out  1  freeze the PC and the pipeline registers.
- o_done  out  1  one-cycle pulse when the program ends.
- o_err  out  1  sticky protocol error.
- o_state  out  3  current state encoding, for debug.

## Operation

- States and encodings: IDLE=0, LOAD_CNT=1, LOAD_DATA=2, RST_PIPE=3, RUN=4, STEP=5.
- IDLE (o_halt=1). The byte is decoded only when i_rx_valid=1:
  - 0x4C 'L' → LOAD_CNT.
  - 0x43 'C' → RST_PIPE with mode=run.
  - 0x53 'S' → RST_PIPE with mode=step.
  - Any other byte sets o_err and stays in IDLE.
  - Accepting a valid command clears o_err.
- LOAD_CNT: the next byte is N.
  - N=0 or N>MAX_INSTR: set o_err, go to IDLE.
  - Otherwise latch N, clear the word counter and byte index, and set the write address to 0. Go to LOAD_DATA.
- LOAD_DATA: bytes arrive MSB first and are shifted into a 32-bit assembly register.
  - On the 4th byte: the assembled word is written to the current address (o_instr_we pulses), the address increments, and the byte index returns to 0.
  - After word N is written, go to IDLE.
- RST_PIPE: lasts one cycle with o_pipe_rst=1 and o_halt=1. Next state is RUN or STEP according to mode.
- RUN: o_halt=0. On i_end_detect=1, go to IDLE. In that first IDLE cycle o_halt=1 and o_done=1. Received bytes are ignored in RUN.
- STEP: o_halt=1 by default.
  - Byte 0x4E 'N': o_halt=0 for exactly one cycle.
  - Byte 0x45 'E': go to IDLE without o_done.
  - Any other byte is ignored.
  - i_end_detect=1: go to IDLE with o_done pulse.
- Simultaneous i_end_detect=1 and 'N' in STEP: end wins, no step cycle is issued.
- i_end_detect is ignored outside RUN and STEP.

## Timing

- All outputs are registered and respond in the cycle after the sampling edge.
- Reset values: state IDLE, o_halt=1, o_instr_we=0, o_instr_addr=0, o_instr_data=0, o_pipe_rst=0, o_done=0, o_err=0, mode=run, all counters 0.
- i_rst at any point, including mid-load or mid-run, returns all reset values on the next edge. A partial word is discarded.
- Load latency: o_instr_we is high for exactly the one cycle after the 4th byte's strobe edge. o_instr_addr and o_instr_data are valid in that same cycle.
- o_instr_addr and o_instr_data hold their last values after a load until the next 'L'.
- Command to pipeline: 'C' strobe at edge k gives o_pipe_rst=1 in cycle k+1 and o_halt=0 from cycle k+2.
- Step: 'N' strobe at edge k gives o_halt=0 in cycle k+1 only.
- Back-to-back strobes, with i_rx_valid high on consecutive cycles, are supported in every state.

## Configuration

- PIPE_CTRL_STEP_EN defined: STEP mode as described.
- Not defined: the STEP state and the step logic are removed. 'S' in IDLE is treated as an unknown command and sets o_err. State encoding 5 is unused.

## Test plan

- Reset, then 0x4C 0x02 00 22 18 21 20 A2 00 04 → two one-cycle we pulses: addr 0 with 0x00221821, addr 1 with 0x20A20004. Then IDLE with o_halt=1.
- 0x4C 0x00 → o_err=1, IDLE, no write. A following 0x43 clears o_err.
- 0x43, then i_end_detect after 10 cycles:
  - o_pipe_rst is high exactly 1 cycle, then o_halt=0 for 10 cycles.
  - Then o_halt=1 and o_done=1 for 1 cycle, state 0.
- 0x53 0x4E 0x4E 0x45 → o_halt is low for 2 total single cycles, each following an 'N'. 'E' returns to IDLE with no o_done. Without PIPE_CTRL_STEP_EN, 0x53 sets o_err.
- 0x4C 0x01 0x00 0x22, then i_rst → no write, all outputs at reset values. A fresh load then writes addr 0.
- STEP with 'N' and i_end_detect in the same cycle → o_halt stays 1, o_done pulses, state IDLE.
